// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-serial scratch memory and its word master.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_e;

  localparam int BEATS  = 4;
  localparam int BYTE_W = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Byte lane idx of a little-endian word.
  function automatic logic [BYTE_W-1:0] word_byte(input logic [BEATS*BYTE_W-1:0] word,
                                                  input logic [1:0]              idx);
    return word[idx*BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/mem_beat_ctr.sv
// Free-running memory phase counter plus a per-frame beat counter with terminal count.
module mem_beat_ctr
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       adv_i,
  output logic [1:0] ph_o,
  output logic [1:0] beat_o,
  output logic       beat_tc_o
);

  // Power-up value only: the memory's own beat counter is never reset, so this
  // one must not be either or the two would drift out of frame alignment.
  logic [1:0] ph_q = 2'd0;
  logic [1:0] beat_q;
  logic [1:0] beat_d;

  always_ff @(posedge clk) begin
    ph_q <= ph_q + 2'd1;
  end

  always_comb begin
    beat_d = beat_q;
    if (start_i) begin
      beat_d = 2'd0;
    end else if (adv_i) begin
      beat_d = beat_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q <= 2'd0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign ph_o      = ph_q;
  assign beat_o    = beat_q;
  assign beat_tc_o = (beat_q == 2'(BEATS - 1));

endmodule

// File: rtl/mem_word_master.sv
// Host-side word master for the byte-serial scratch memory: one 32-bit read or write
// per handshake, serialised as four byte beats aligned to the memory's phase.
module mem_word_master
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_rw_select,
  output logic [BYTE_W-1:0] mem_data_in,
  input  logic [BYTE_W-1:0] mem_data_out
);

  if (WORD_W != BEATS * BYTE_W) begin : g_bad_word_w
    $error("mem_word_master: WORD_W must equal %0d", BEATS * BYTE_W);
  end

  state_e            state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rd_arm_q;
  logic              mem_rw_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [BYTE_W-1:0] mem_din_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] shadow_q;
  logic [WORD_W-1:0] rsp_rdata_q;

  logic [1:0]        ph;
  logic [1:0]        beat;
  logic              beat_tc;
  logic              hs;
  logic              beat_adv;

  assign hs = req_valid & req_ready_q;
  // A read spends its launch cycle waiting for the memory's registered data_out.
  assign beat_adv = (state_q == WR) || ((state_q == RD) && rd_arm_q);

  mem_beat_ctr u_beat_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (hs),
    .adv_i     (beat_adv),
    .ph_o      (ph),
    .beat_o    (beat),
    .beat_tc_o (beat_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rd_arm_q    <= 1'b0;
      mem_rw_q    <= RW_READ;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      wdata_q     <= '0;
      shadow_q    <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      // Ready is registered one cycle early so it is high exactly on ph = 3.
      req_ready_q <= (ph == 2'd2) && ((state_q == IDLE) || (state_q == RSP));

      case (state_q)
        IDLE: begin
          if (hs) begin
            mem_addr_q <= req_addr;
            mem_rw_q   <= req_rw;
            mem_din_q  <= word_byte(req_wdata, 2'd0);
            wdata_q    <= req_wdata;
            rd_arm_q   <= 1'b0;
            state_q    <= (req_rw == RW_READ) ? RD : WR;
          end
        end

        WR: begin
          if (beat_tc) begin
            mem_rw_q    <= RW_READ;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end else begin
            mem_din_q <= word_byte(wdata_q, beat + 2'd1);
          end
        end

        RD: begin
          rd_arm_q <= 1'b1;
          if (rd_arm_q) begin
            shadow_q[beat*BYTE_W +: BYTE_W] <= mem_data_out;
            if (beat_tc) begin
              rsp_rdata_q <= {mem_data_out, shadow_q[WORD_W-BYTE_W-1:0]};
              rsp_valid_q <= 1'b1;
              rd_arm_q    <= 1'b0;
              state_q     <= RSP;
            end
          end
        end

        RSP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign mem_address   = mem_addr_q;
  assign mem_rw_select = mem_rw_q;
  assign mem_data_in   = mem_din_q;

endmodule
